// File: rtl/regfile_sequencer_pkg.sv
// Shared opcode and state definitions for the register-file command sequencer.
// Any block that decodes sequencer commands imports these encodings.
package regfile_sequencer_pkg;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_WR1  = 3'd3,
        ST_WR2  = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Multi-cycle register-file command sequencer (LDI/MOV/SWAP/CLR).
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_iaddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_oe,
    output logic [ADDR_W-1:0] rf_oaddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [2:0]        o_dbg_state
);

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W-1:0]   r_src;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_temp_a;
    logic [DATA_W-1:0]   r_temp_b;
    logic                r_done;

    state_t              w_next_state;
    logic                w_accept;
    logic                w_final_wr;

    assign cmd_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = cmd_valid && cmd_ready;
    assign done        = r_done;
    assign o_dbg_state = r_state;

    // done is raised in the IDLE cycle that follows whichever write state ends the command.
    assign w_final_wr  = ((r_state == ST_WR1) && (r_op != OP_SWAP)) || (r_state == ST_WR2);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ((cmd_op == OP_MOV) || (cmd_op == OP_SWAP)) ? ST_RD1 : ST_WR1;
                end
            end
            ST_RD1:  w_next_state = (r_op == OP_SWAP) ? ST_RD2 : ST_WR1;
            ST_RD2:  w_next_state = ST_WR1;
            ST_WR1:  w_next_state = (r_op == OP_SWAP) ? ST_WR2 : ST_IDLE;
            ST_WR2:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Moore decode of the register-file strobes; address/data stay 0 while their strobe is low.
    always_comb begin
        rf_we    = 1'b0;
        rf_iaddr = '0;
        rf_wdata = '0;
        rf_oe    = 1'b0;
        rf_oaddr = '0;
        case (r_state)
            ST_RD1: begin
                rf_oe    = 1'b1;
                rf_oaddr = (r_op == OP_SWAP) ? r_dst : r_src;
            end
            ST_RD2: begin
                rf_oe    = 1'b1;
                rf_oaddr = r_src;
            end
            ST_WR1: begin
                rf_we    = 1'b1;
                rf_iaddr = r_dst;
                case (r_op)
                    OP_LDI:  rf_wdata = r_imm;
                    OP_MOV:  rf_wdata = r_temp_a;
                    OP_SWAP: rf_wdata = r_temp_b;
                    default: rf_wdata = '0;
                endcase
            end
            ST_WR2: begin
                rf_we    = 1'b1;
                rf_iaddr = r_src;
                rf_wdata = r_temp_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_dst    <= '0;
            r_src    <= '0;
            r_imm    <= '0;
            r_temp_a <= '0;
            r_temp_b <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_final_wr;
            if (w_accept) begin
                r_op  <= cmd_op;
                r_dst <= cmd_dst;
                r_src <= cmd_src;
                r_imm <= cmd_imm;
            end
            if (r_state == ST_RD1) begin
                r_temp_a <= rf_rdata;
            end
            if (r_state == ST_RD2) begin
                r_temp_b <= rf_rdata;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: table of commands against a behavioural
// register file, plus back-to-back and mid-command reset sequences.
module tb_regfile_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_dst;
    logic [2:0] cmd_src;
    logic [7:0] cmd_imm;
    logic       done;
    logic       rf_we;
    logic [2:0] rf_iaddr;
    logic [7:0] rf_wdata;
    logic       rf_oe;
    logic [2:0] rf_oaddr;
    logic [7:0] rf_rdata;
    logic [2:0] dbg_state;

    logic [7:0] regs [8];
    logic       pre_we;
    logic [2:0] pre_addr;
    logic [7:0] pre_data;

    int checks;
    int failures;

    regfile_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_src    (cmd_src),
        .cmd_imm    (cmd_imm),
        .done       (done),
        .rf_we      (rf_we),
        .rf_iaddr   (rf_iaddr),
        .rf_wdata   (rf_wdata),
        .rf_oe      (rf_oe),
        .rf_oaddr   (rf_oaddr),
        .rf_rdata   (rf_rdata),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural register file with combinational read port
    always @(posedge clk) begin
        if (pre_we) regs[pre_addr] <= pre_data;
        else if (rf_we) regs[rf_iaddr] <= rf_wdata;
    end
    assign rf_rdata = rf_oe ? regs[rf_oaddr] : 8'h00;

    typedef struct {
        logic [1:0] op;
        logic [2:0] dst;
        logic [2:0] src;
        logic [7:0] imm;
        int         lat;
        int         n_rd;
        logic [2:0] rd0;
        logic [2:0] rd1;
        int         n_wr;
        logic [2:0] wa0;
        logic [7:0] wd0;
        logic [2:0] wa1;
        logic [7:0] wd1;
        logic [2:0] ca;
        logic [7:0] cd;
        logic [2:0] cb;
        logic [7:0] ce;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                                input logic [7:0] imm, input int lat, input int n_rd,
                                input logic [2:0] rd0, input logic [2:0] rd1, input int n_wr,
                                input logic [2:0] wa0, input logic [7:0] wd0,
                                input logic [2:0] wa1, input logic [7:0] wd1,
                                input logic [2:0] ca, input logic [7:0] cd,
                                input logic [2:0] cb, input logic [7:0] ce);
        vec_t v;
        v.op = op; v.dst = dst; v.src = src; v.imm = imm; v.lat = lat;
        v.n_rd = n_rd; v.rd0 = rd0; v.rd1 = rd1;
        v.n_wr = n_wr; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ca = ca; v.cd = cd; v.cb = cb; v.ce = ce;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Offer a command (starting at a negedge) and return once it has been accepted (#1 past the edge).
    task automatic issue(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [7:0] imm, input logic keep_valid);
        int waited;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t       v;
        int         cyc;
        int         n_rd;
        int         n_wr;
        logic [2:0] rd_a [4];
        logic [2:0] wr_a [4];
        logic [7:0] wr_d [4];
        logic       got_done;
        logic       bad_zero;
        logic       bad_ready;
        v = vecs[k];
        n_rd = 0; n_wr = 0; cyc = 0; got_done = 1'b0; bad_zero = 1'b0; bad_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_a[i] = '0; wr_a[i] = '0; wr_d[i] = '0;
        end
        issue(v.op, v.dst, v.src, v.imm, 1'b0);
        while (!got_done && cyc < 20) begin
            @(negedge clk);
            if (rf_we && rf_oe) bad_zero = 1'b1;
            if (!rf_we && (rf_iaddr != 3'd0 || rf_wdata != 8'h00)) bad_zero = 1'b1;
            if (!rf_oe && rf_oaddr != 3'd0) bad_zero = 1'b1;
            if (done) begin
                got_done = 1'b1;
                if (rf_we || rf_oe || !cmd_ready) bad_zero = 1'b1;
            end else begin
                cyc++;
                if (cmd_ready) bad_ready = 1'b1;
                if (rf_oe && n_rd < 4) begin rd_a[n_rd] = rf_oaddr; n_rd++; end
                if (rf_we && n_wr < 4) begin wr_a[n_wr] = rf_iaddr; wr_d[n_wr] = rf_wdata; n_wr++; end
            end
        end
        @(negedge clk);
        check($sformatf("v%0d_done_seen", k), {31'd0, got_done}, 32'd1);
        check($sformatf("v%0d_latency", k), cyc, v.lat);
        check($sformatf("v%0d_done_one_cycle", k), {31'd0, done}, 32'd0);
        check($sformatf("v%0d_strobe_rules", k), {31'd0, bad_zero}, 32'd0);
        check($sformatf("v%0d_ready_low_busy", k), {31'd0, bad_ready}, 32'd0);
        check($sformatf("v%0d_n_rd", k), n_rd, v.n_rd);
        check($sformatf("v%0d_n_wr", k), n_wr, v.n_wr);
        if (v.n_rd > 0) check($sformatf("v%0d_rd0", k), {29'd0, rd_a[0]}, {29'd0, v.rd0});
        if (v.n_rd > 1) check($sformatf("v%0d_rd1", k), {29'd0, rd_a[1]}, {29'd0, v.rd1});
        check($sformatf("v%0d_wa0", k), {29'd0, wr_a[0]}, {29'd0, v.wa0});
        check($sformatf("v%0d_wd0", k), {24'd0, wr_d[0]}, {24'd0, v.wd0});
        if (v.n_wr > 1) begin
            check($sformatf("v%0d_wa1", k), {29'd0, wr_a[1]}, {29'd0, v.wa1});
            check($sformatf("v%0d_wd1", k), {24'd0, wr_d[1]}, {24'd0, v.wd1});
        end
        check($sformatf("v%0d_reg_a", k), {24'd0, regs[v.ca]}, {24'd0, v.cd});
        check($sformatf("v%0d_reg_b", k), {24'd0, regs[v.cb]}, {24'd0, v.ce});
    endtask

    localparam logic [1:0] LDI = 2'b00, MOV = 2'b01, SWP = 2'b10, CLR = 2'b11;

    initial begin
        logic seen_we;
        logic seen_done;
        checks = 0; failures = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0; cmd_imm = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Start contents: r0=12 r1=11 r2=22 r3=33 r4=44 r5=55 r6=66 r7=77
        vecs[0] = mk(LDI, 3, 0, 8'hA5, 1, 0, 0, 0, 1, 3, 8'hA5, 0, 8'h00, 3, 8'hA5, 3, 8'hA5);
        vecs[1] = mk(MOV, 5, 0, 8'h00, 2, 1, 0, 0, 1, 5, 8'h12, 0, 8'h00, 5, 8'h12, 0, 8'h12);
        vecs[2] = mk(SWP, 1, 2, 8'h00, 4, 2, 1, 2, 2, 1, 8'h22, 2, 8'h11, 1, 8'h22, 2, 8'h11);
        vecs[3] = mk(CLR, 7, 0, 8'h5A, 1, 0, 0, 0, 1, 7, 8'h00, 0, 8'h00, 7, 8'h00, 6, 8'h66);
        vecs[4] = mk(MOV, 6, 6, 8'h00, 2, 1, 6, 0, 1, 6, 8'h66, 0, 8'h00, 6, 8'h66, 5, 8'h12);
        vecs[5] = mk(SWP, 4, 4, 8'h00, 4, 2, 4, 4, 2, 4, 8'h44, 4, 8'h44, 4, 8'h44, 3, 8'hA5);
        vecs[6] = mk(LDI, 0, 0, 8'hFF, 1, 0, 0, 0, 1, 0, 8'hFF, 0, 8'h00, 0, 8'hFF, 1, 8'h22);
        vecs[7] = mk(SWP, 0, 3, 8'h00, 4, 2, 0, 3, 2, 0, 8'hA5, 3, 8'hFF, 0, 8'hA5, 3, 8'hFF);

        @(negedge clk);
        for (int i = 0; i < 8; i++) preload(i[2:0], (i == 0) ? 8'h12 : {i[3:0], i[3:0]});
        check("ready_low_in_reset", {31'd0, cmd_ready}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        check("reset_strobes", {30'd0, rf_we, rf_oe}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_vec(k);

        // Back-to-back: LDI r4=01, then CLR r4 offered with cmd_valid held high
        issue(LDI, 4, 0, 8'h01, 1'b1);
        cmd_op = CLR; cmd_dst = 3'd4; cmd_imm = 8'h77;
        @(negedge clk);
        check("b2b_ldi_write", {rf_we, rf_iaddr, rf_wdata}, {20'd0, 1'b1, 3'd4, 8'h01});
        @(negedge clk);
        check("b2b_done_and_ready", {30'd0, done, cmd_ready}, 32'd3);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("b2b_reg4_ldi", {24'd0, regs[4]}, 32'h01);
        @(negedge clk);
        check("b2b_clr_write", {rf_we, rf_iaddr, rf_wdata}, {20'd0, 1'b1, 3'd4, 8'h00});
        @(negedge clk);
        check("b2b_clr_done", {31'd0, done}, 32'd1);
        check("b2b_reg4_final", {24'd0, regs[4]}, 32'h00);
        @(negedge clk);

        // Reset during RD2 of SWAP r1/r2 (r1=22, r2=11)
        issue(SWP, 1, 2, 8'h00, 1'b0);
        @(negedge clk);
        check("rst_rd1_read", {rf_oe, rf_oaddr}, {28'd0, 1'b1, 3'd1});
        @(negedge clk);
        check("rst_rd2_read", {rf_oe, rf_oaddr}, {28'd0, 1'b1, 3'd2});
        rst = 1'b1;
        #1;
        check("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("rst_idle", {29'd0, dbg_state}, 32'd0);
        check("rst_outputs_zero", {done, rf_we, rf_oe, rf_iaddr, rf_oaddr, rf_wdata}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_after", {31'd0, cmd_ready}, 32'd1);
        seen_we = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rf_we) seen_we = 1'b1;
            if (done) seen_done = 1'b1;
        end
        check("rst_no_write", {31'd0, seen_we}, 32'd0);
        check("rst_no_done", {31'd0, seen_done}, 32'd0);
        check("rst_r1_kept", {24'd0, regs[1]}, 32'h22);
        check("rst_r2_kept", {24'd0, regs[2]}, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
